// File: rtl/rr_merge_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_merge_sched_pkg : shared types and helpers for the RR merge       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rr_merge_sched_pkg;

    localparam int MAX_IN = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_OUT_RTZ = 2'd2,
        ST_IN_RTZ  = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bit i moves to position (i + sh) mod n; sh must lie in 0..n.
    function automatic logic [MAX_IN-1:0] rotl(input logic [MAX_IN-1:0] v,
                                               input int sh, input int n);
        logic [MAX_IN-1:0] r;
        int                k;
        r = '0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (i < n) begin
                k = i + sh;
                if (k >= n) k = k - n;
                r[k] = v[i];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_merge_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_merge_sched_if : producer-side and consumer-side handshake bundle |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rr_merge_sched_if
    import rr_merge_sched_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16
) ();
    localparam int IDX_W = idx_width(NUM_IN);

    logic [NUM_IN-1:0]       in_req;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ack;
    logic                    out_req;
    logic [WIDTH-1:0]        out_data;
    logic                    out_ack;
    logic                    busy;
    logic [IDX_W-1:0]        last_grant;
    logic [CNT_W-1:0]        grant_count;

    modport slave (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, busy, last_grant, grant_count
    );

    modport master (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, busy, last_grant, grant_count
    );
endinterface
`default_nettype wire

// File: rtl/rr_merge_sched_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_merge_sched_rr_pick : rotating-priority picker starting at i_ptr  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_merge_sched_rr_pick
    import rr_merge_sched_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int IDX_W  = 1
) (
    input  wire logic [NUM_IN-1:0] i_req,
    input  wire logic [IDX_W-1:0]  i_ptr,
    output logic      [NUM_IN-1:0] o_grant,
    output logic      [IDX_W-1:0]  o_idx,
    output logic                   o_any
);
    logic [MAX_IN-1:0] w_rot;

    always_comb begin
        int k;
        k       = 0;
        // After rotation, bit j holds the request of channel (j + ptr) mod NUM_IN.
        w_rot   = rotl(MAX_IN'(i_req), NUM_IN - int'(i_ptr), NUM_IN);
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int j = 0; j < MAX_IN; j++) begin
            if (j < NUM_IN && !o_any && w_rot[j]) begin
                o_any = 1'b1;
                k     = j + int'(i_ptr);
                if (k >= NUM_IN) k = k - NUM_IN;
                o_idx      = IDX_W'(k);
                o_grant[k] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rr_merge_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_merge_sched : fair round-robin merge of four-phase channels       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_merge_sched
    import rr_merge_sched_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16
) (
    input wire logic        clk,
    input wire logic        reset,
    rr_merge_sched_if.slave bus
);
    localparam int IDX_W = idx_width(NUM_IN);

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_IN-1:0]   r_in_ack;
    logic [NUM_IN-1:0]   r_g_oh;
    logic [IDX_W-1:0]    r_g;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_last_grant;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_req;
    logic                r_busy;
    logic [CNT_W-1:0]    r_grant_count;

    logic [NUM_IN-1:0]   w_elig;
    logic [NUM_IN-1:0]   w_pick_grant;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic [IDX_W-1:0]    w_ptr_next;
    logic                w_load;
    logic                w_send_done;
    logic                w_ack_set;
    logic                w_done;

    assign w_elig = bus.in_req & ~r_in_ack;

    rr_merge_sched_rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_pick_any)                     w_state_next = ST_SEND;
            ST_SEND:    if (bus.out_ack)                    w_state_next = ST_OUT_RTZ;
            ST_OUT_RTZ: if (!bus.out_ack)                   w_state_next = ST_IN_RTZ;
            ST_IN_RTZ:  if ((bus.in_req & r_g_oh) == '0)    w_state_next = ST_IDLE;
            default:                                        w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load      = (r_state == ST_IDLE)    && w_pick_any;
        w_send_done = (r_state == ST_SEND)    && bus.out_ack;
        w_ack_set   = (r_state == ST_OUT_RTZ) && !bus.out_ack;
        w_done      = (r_state == ST_IN_RTZ)  && ((bus.in_req & r_g_oh) == '0);
        if (int'(r_g) + 1 >= NUM_IN) w_ptr_next = '0;
        else                         w_ptr_next = r_g + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ack      <= '0;
            r_g_oh        <= '0;
            r_g           <= '0;
            r_ptr         <= '0;
            r_last_grant  <= '0;
            r_out_data    <= '0;
            r_out_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_count <= '0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            if (w_load) begin
                r_g        <= w_pick_idx;
                r_g_oh     <= w_pick_grant;
                r_out_data <= bus.in_data[int'(w_pick_idx)*WIDTH +: WIDTH];
                r_out_req  <= 1'b1;
            end
            if (w_send_done) r_out_req <= 1'b0;
            if (w_ack_set)   r_in_ack  <= r_g_oh;
            // The producer has returned to zero: release it and rotate priority past it.
            if (w_done) begin
                r_in_ack      <= '0;
                r_ptr         <= w_ptr_next;
                r_last_grant  <= r_g;
                r_grant_count <= r_grant_count + 1'b1;
            end
        end
    end

    assign bus.in_ack      = r_in_ack;
    assign bus.out_req     = r_out_req;
    assign bus.out_data    = r_out_data;
    assign bus.busy        = r_busy;
    assign bus.last_grant  = r_last_grant;
    assign bus.grant_count = r_grant_count;
endmodule
`default_nettype wire

// File: tb/tb_rr_merge_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_merge_sched : scoreboard bench for the round-robin merge       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rr_merge_sched;
    import rr_merge_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_req;
    logic [15:0] in_data;
    logic        out_ack;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;

    typedef struct {
        logic [7:0] data;
        int         idx;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rr_merge_sched_if #(.NUM_IN(2), .WIDTH(8), .CNT_W(16)) bus   ();
    rr_merge_sched_if #(.NUM_IN(2), .WIDTH(8), .CNT_W(4))  bus_w ();

    assign bus.in_req    = in_req;
    assign bus.in_data   = in_data;
    assign bus.out_ack   = out_ack;
    assign bus_w.in_req  = in_req;
    assign bus_w.in_data = in_data;
    assign bus_w.out_ack = out_ack;

    rr_merge_sched #(.NUM_IN(2), .WIDTH(8), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rr_merge_sched #(.NUM_IN(2), .WIDTH(8), .CNT_W(4)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    // One cycle step: sample after the falling edge, then producers return to zero on ack.
    task automatic tick();
        @(negedge clk);
        if ($countones(bus.in_ack) > 1 || (bus.in_ack != 2'b00 && bus.out_req === 1'b1)) viol++;
        for (int i = 0; i < 2; i++)
            if (bus.in_ack[i] === 1'b1) in_req[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        in_req  = 2'b00;
        out_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Consumer: accept one word with dly cycles of ack delay, report what was seen.
    task automatic serve(input int dly, output logic [7:0] data, output int idx,
                         output bit ok, output bit held);
        int n;
        ok   = 1'b1;
        held = 1'b1;
        idx  = -1;
        data = '0;
        n = 0;
        while (bus.out_req !== 1'b1 && n < 100) begin tick(); n++; end
        if (bus.out_req !== 1'b1) begin ok = 1'b0; return; end
        data = bus.out_data;
        for (int k = 0; k < dly; k++) begin
            tick();
            if (bus.out_req !== 1'b1 || bus.out_data !== data || bus.in_ack !== 2'b00) held = 1'b0;
        end
        out_ack = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.out_req !== 1'b0 && n < 100);
        out_ack = 1'b0;
        if (bus.out_req !== 1'b0) begin ok = 1'b0; return; end
        n = 0;
        do begin tick(); n++; end while (bus.in_ack === 2'b00 && n < 100);
        if (bus.in_ack === 2'b00) begin ok = 1'b0; return; end
        for (int i = 0; i < 2; i++) if (bus.in_ack[i] === 1'b1) idx = i;
        tick();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        in_req  = 2'b00;
        in_data = '0;
        out_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.out_req !== 1'b0) $display("FAIL rst_out_req: got %b want 0", bus.out_req); else n_pass++;
        n_checks++; if (bus.in_ack !== 2'b00) $display("FAIL rst_in_ack: got %b want 00", bus.in_ack); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h00) $display("FAIL rst_out_data: got %h want 00", bus.out_data); else n_pass++;
        n_checks++; if (bus.last_grant !== 1'b0) $display("FAIL rst_last_grant: got %b want 0", bus.last_grant); else n_pass++;
        n_checks++; if (bus.grant_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", bus.grant_count); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single(input int ch, input logic [7:0] d, input logic [15:0] cnt_exp);
        logic [7:0] got; int idx; bit ok, held;
        exp_t e;
        in_data[ch*8 +: 8] = d;
        in_req[ch]         = 1'b1;
        sb.push_back('{d, ch});
        serve(2, got, idx, ok, held);
        e = sb.pop_front();
        n_checks++; if (!ok) $display("FAIL single%0d_timeout: handshake did not complete", ch); else n_pass++;
        n_checks++; if (got !== e.data) $display("FAIL single%0d_data: got %h want %h", ch, got, e.data); else n_pass++;
        n_checks++; if (idx !== e.idx) $display("FAIL single%0d_ack_ch: got %0d want %0d", ch, idx, e.idx); else n_pass++;
        n_checks++; if (int'(bus.last_grant) !== e.idx) $display("FAIL single%0d_last_grant: got %0d want %0d", ch, bus.last_grant, e.idx); else n_pass++;
        n_checks++; if (bus.grant_count !== cnt_exp) $display("FAIL single%0d_count: got %0d want %0d", ch, bus.grant_count, cnt_exp); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] got; int idx; bit ok, held;
        logic [7:0] d0, d1;
        exp_t e;
        do_reset();
        viol = 0;
        for (int it = 0; it < 32; it++) begin
            d0 = (it == 0) ? 8'h11 : 8'($urandom);
            d1 = (it == 0) ? 8'h22 : 8'($urandom);
            in_data = {d1, d0};
            in_req  = 2'b11;
            sb.push_back('{d0, 0});
            sb.push_back('{d1, 1});
            for (int w = 0; w < 2; w++) begin
                serve(0, got, idx, ok, held);
                e = sb.pop_front();
                n_checks++; if (!ok || got !== e.data) $display("FAIL sim_data it%0d: got %h want %h ok=%0d", it, got, e.data, ok); else n_pass++;
                n_checks++; if (idx !== e.idx) $display("FAIL sim_order it%0d: got ch %0d want ch %0d", it, idx, e.idx); else n_pass++;
            end
        end
        n_checks++; if (bus.grant_count !== 16'd64) $display("FAIL sim_count: got %0d want 64", bus.grant_count); else n_pass++;
        n_checks++; if (bus_w.grant_count !== 4'd0) $display("FAIL sim_count4: got %0d want 0", bus_w.grant_count); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL ack_exclusive: got %0d violations want 0", viol); else n_pass++;
    endtask

    task automatic test_slow_consumer();
        logic [7:0] got; int idx; bit ok, held;
        in_data[7:0] = 8'h5C;
        in_req[0]    = 1'b1;
        serve(10, got, idx, ok, held);
        n_checks++; if (!ok || got !== 8'h5C) $display("FAIL slow_data: got %h want 5c ok=%0d", got, ok); else n_pass++;
        n_checks++; if (held !== 1'b1) $display("FAIL slow_hold: got %0d want 1 (req high, data stable, no ack)", held); else n_pass++;
        n_checks++; if (bus.grant_count !== 16'd65) $display("FAIL slow_count: got %0d want 65", bus.grant_count); else n_pass++;
    endtask

    task automatic test_violation();
        logic [7:0] got; int idx; bit ok, held;
        int n;
        in_data[15:8] = 8'h7E;
        in_req[1]     = 1'b1;
        n = 0;
        while (bus.out_req !== 1'b1 && n < 50) begin tick(); n++; end
        in_req[1] = 1'b0;
        serve(1, got, idx, ok, held);
        n_checks++; if (!ok || got !== 8'h7E) $display("FAIL viol_data: got %h want 7e ok=%0d", got, ok); else n_pass++;
        n_checks++; if (idx !== 1) $display("FAIL viol_ack_ch: got %0d want 1", idx); else n_pass++;
        n_checks++; if (bus.grant_count !== 16'd66) $display("FAIL viol_count: got %0d want 66", bus.grant_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got; int idx; bit ok, held;
        int n;
        exp_t e;
        in_data[7:0] = 8'h31;
        in_req[0]    = 1'b1;
        serve(0, got, idx, ok, held);
        in_data[15:8] = 8'h99;
        in_req[1]     = 1'b1;
        n = 0;
        while (bus.out_req !== 1'b1 && n < 50) begin tick(); n++; end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.out_req !== 1'b0) $display("FAIL mid_out_req: got %b want 0", bus.out_req); else n_pass++;
        n_checks++; if (bus.in_ack !== 2'b00) $display("FAIL mid_in_ack: got %b want 00", bus.in_ack); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.grant_count !== 16'd0) $display("FAIL mid_count: got %0d want 0", bus.grant_count); else n_pass++;
        @(negedge clk);
        reset  = 1'b0;
        in_req = 2'b00;
        tick();
        in_data = {8'h44, 8'h33};
        in_req  = 2'b11;
        sb.push_back('{8'h33, 0});
        sb.push_back('{8'h44, 1});
        for (int w = 0; w < 2; w++) begin
            serve(0, got, idx, ok, held);
            e = sb.pop_front();
            n_checks++; if (!ok || got !== e.data) $display("FAIL mid_after_data%0d: got %h want %h", w, got, e.data); else n_pass++;
            n_checks++; if (idx !== e.idx) $display("FAIL mid_after_ptr%0d: got ch %0d want ch %0d", w, idx, e.idx); else n_pass++;
        end
        n_checks++; if (bus.last_grant !== 1'b1) $display("FAIL mid_last_grant: got %0d want 1", bus.last_grant); else n_pass++;
        n_checks++; if (bus.grant_count !== 16'd2) $display("FAIL mid_after_count: got %0d want 2", bus.grant_count); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] got; int idx; bit ok, held;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            in_data[7:0] = 8'(k + 1);
            in_req[0]    = 1'b1;
            serve(0, got, idx, ok, held);
        end
        n_checks++; if (bus_w.grant_count !== 4'd1) $display("FAIL wrap_count4: got %0d want 1", bus_w.grant_count); else n_pass++;
        n_checks++; if (bus.grant_count !== 16'd17) $display("FAIL wrap_count16: got %0d want 17", bus.grant_count); else n_pass++;
        n_checks++; if (got !== 8'h11) $display("FAIL wrap_last_data: got %h want 11", got); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL sb_drain: got %0d entries want 0", sb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single(0, 8'h2A, 16'd1);
        test_single(1, 8'h15, 16'd2);
        test_simultaneous();
        test_slow_consumer();
        test_violation();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
